// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch digit registers: BCD digit, decoded
// button command and the step FSM state encoding.
package stopwatch_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_INC  = 2'b01,
        CMD_DEC  = 2'b10
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PRESS  = 2'b01,
        REPEAT = 2'b10
    } step_state_t;

    // Only a clean single-direction request with the enable asserted is a command;
    // the conflicting 11 code and anything while disabled collapse to idle.
    function automatic cmd_t decode_cmd(input logic en, input logic [1:0] sig);
        cmd_t result;
        result = CMD_IDLE;
        if (en) begin
            case (sig)
                2'b01:   result = CMD_INC;
                2'b10:   result = CMD_DEC;
                default: result = CMD_IDLE;
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_step.sv
// One increment or decrement of a two-digit BCD value with wrap at a
// configurable maximum. Purely combinational.
module bcd_step
    import stopwatch_pkg::*;
(
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       dir,
    input  logic [3:0] max_tens,
    input  logic [3:0] max_ones,
    output logic [3:0] next_tens,
    output logic [3:0] next_ones,
    output logic       wrap
);

    // dir=0 counts up and wraps max->00, dir=1 counts down and wraps 00->max
    always_comb begin
        next_tens = tens;
        next_ones = ones;
        wrap      = 1'b0;
        if (!dir) begin
            if ((tens == max_tens) && (ones == max_ones)) begin
                next_tens = 4'd0;
                next_ones = 4'd0;
                wrap      = 1'b1;
            end else if (ones == 4'd9) begin
                next_ones = 4'd0;
                next_tens = tens + 4'd1;
            end else begin
                next_ones = ones + 4'd1;
            end
        end else begin
            if ((tens == 4'd0) && (ones == 4'd0)) begin
                next_tens = max_tens;
                next_ones = max_ones;
                wrap      = 1'b1;
            end else if (ones == 4'd0) begin
                next_ones = 4'd9;
                next_tens = tens - 4'd1;
            end else begin
                next_ones = ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/updown_step_counter.sv
// Settable two-digit BCD register driven by the add/sub button path.
// A held command steps once, waits HOLD_CYCLES, then auto-repeats every
// REPEAT_CYCLES; wrap-around is flagged by one-cycle carry/borrow pulses.
module updown_step_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_COUNT     = 59,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] signal,
    output logic [3:0] count_tens,
    output logic [3:0] count_ones,
    output logic       carry,
    output logic       borrow,
    output logic       active
);

    localparam int TIMER_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX);

    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);
    localparam logic [3:0]         MAX_TENS    = 4'(MAX_COUNT / 10);
    localparam logic [3:0]         MAX_ONES    = 4'(MAX_COUNT % 10);

    logic [1:0]         signal_s1;
    logic [1:0]         signal_s2;
    logic               enable_s1;
    logic               enable_s2;
    cmd_t               cmd;
    cmd_t               dir_cmd;
    step_state_t        state;
    logic [TIMER_W-1:0] timer;
    logic               step_en;
    logic [3:0]         next_tens;
    logic [3:0]         next_ones;
    logic               wrap;

    // Two-flop synchronizer: button path is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signal_s1 <= 2'b00;
            signal_s2 <= 2'b00;
            enable_s1 <= 1'b0;
            enable_s2 <= 1'b0;
        end else begin
            signal_s1 <= signal;
            signal_s2 <= signal_s1;
            enable_s1 <= enable;
            enable_s2 <= enable_s1;
        end
    end

    // Decode the synchronized inputs into a command
    always_comb begin
        cmd = decode_cmd(enable_s2, signal_s2);
    end

    // A step happens on a new press, a direction reversal, or a timer expiry
    always_comb begin
        step_en = 1'b0;
        if (cmd != CMD_IDLE) begin
            case (state)
                IDLE:    step_en = 1'b1;
                PRESS:   step_en = (cmd != dir_cmd) || (timer == HOLD_LAST);
                REPEAT:  step_en = (cmd != dir_cmd) || (timer == REPEAT_LAST);
                default: step_en = 1'b0;
            endcase
        end
    end

    // Whenever a step is taken the live command already holds the step direction
    bcd_step u_bcd_step (
        .tens      (count_tens),
        .ones      (count_ones),
        .dir       (cmd == CMD_DEC),
        .max_tens  (MAX_TENS),
        .max_ones  (MAX_ONES),
        .next_tens (next_tens),
        .next_ones (next_ones),
        .wrap      (wrap)
    );

    // Press / hold / auto-repeat sequencing with its cycle timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            dir_cmd <= CMD_IDLE;
            active  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (cmd != CMD_IDLE) begin
                        state   <= PRESS;
                        dir_cmd <= cmd;
                        active  <= 1'b1;
                    end
                end
                PRESS: begin
                    if (cmd == CMD_IDLE) begin
                        state  <= IDLE;
                        timer  <= '0;
                        active <= 1'b0;
                    end else if (cmd != dir_cmd) begin
                        dir_cmd <= cmd;
                        timer   <= '0;
                    end else if (timer == HOLD_LAST) begin
                        state <= REPEAT;
                        timer <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                REPEAT: begin
                    if (cmd == CMD_IDLE) begin
                        state  <= IDLE;
                        timer  <= '0;
                        active <= 1'b0;
                    end else if (cmd != dir_cmd) begin
                        state   <= PRESS;
                        dir_cmd <= cmd;
                        timer   <= '0;
                    end else if (timer == REPEAT_LAST) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    timer  <= '0;
                    active <= 1'b0;
                end
            endcase
        end
    end

    // Count register plus one-cycle wrap pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_tens <= 4'd0;
            count_ones <= 4'd0;
            carry      <= 1'b0;
            borrow     <= 1'b0;
        end else begin
            carry  <= step_en && wrap && (cmd == CMD_INC);
            borrow <= step_en && wrap && (cmd == CMD_DEC);
            if (step_en) begin
                count_tens <= next_tens;
                count_ones <= next_ones;
            end
        end
    end

endmodule

// File: tb/tb_updown_step_counter.sv
// Directed bench for updown_step_counter with short hold/repeat timing.
module tb_updown_step_counter;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [1:0] signal;
    logic [3:0] count_tens;
    logic [3:0] count_ones;
    logic       carry;
    logic       borrow;
    logic       active;

    int tests_run;
    int tests_failed;

    updown_step_counter #(
        .MAX_COUNT     (59),
        .HOLD_CYCLES   (4),
        .REPEAT_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .signal     (signal),
        .count_tens (count_tens),
        .count_ones (count_ones),
        .carry      (carry),
        .borrow     (borrow),
        .active     (active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle command pulse, then enough idle cycles for the FSM to return to IDLE
    task automatic quick_press(input logic [1:0] sig);
        signal = sig;
        tick(1);
        signal = 2'b00;
        tick(4);
    endtask

    task automatic test_reset();
        logic [10:0] got;
        rst_n  = 1'b0;
        enable = 1'b0;
        signal = 2'b00;
        tick(2);
        got = {count_tens, count_ones, carry, borrow, active};
        tests_run++;
        if (got !== 11'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_held: got %h, want 000", got);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            got = {count_tens, count_ones, carry, borrow, active};
            tests_run++;
            if (got !== 11'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_release cycle %0d: got %h, want 000", k, got);
            end
        end
    endtask

    task automatic test_single_press();
        logic [9:0] got;
        logic [9:0] exp;
        logic [7:0] exp_cnt [8];
        logic       exp_act [8];
        exp_cnt = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        exp_act = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        enable = 1'b1;
        signal = 2'b01;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            got = {count_tens, count_ones, carry, active};
            exp = {exp_cnt[k], 1'b0, exp_act[k]};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("[TB] FAIL single_press edge N+%0d: cnt=%h%h carry=%b active=%b, want cnt=%h active=%b",
                         k, count_tens, count_ones, carry, active, exp_cnt[k], exp_act[k]);
            end
            if (k == 2) signal = 2'b00;
        end
    endtask

    task automatic test_decrement_wrap();
        logic [9:0] got;
        logic [9:0] exp;
        quick_press(2'b10);
        tests_run++;
        if ({count_tens, count_ones} !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL dec_to_zero: cnt=%h%h, want 00", count_tens, count_ones);
        end
        signal = 2'b10;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (k == 0) signal = 2'b00;
            got = {count_tens, count_ones, carry, borrow};
            exp = {((k < 2) ? 8'h00 : 8'h59), 1'b0, (k == 2)};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("[TB] FAIL borrow_wrap edge N+%0d: cnt=%h%h carry=%b borrow=%b, want %h",
                         k, count_tens, count_ones, carry, borrow, exp);
            end
        end
    endtask

    task automatic test_repeat_wrap();
        logic [9:0] got;
        logic [9:0] exp;
        logic [7:0] exp_cnt [17];
        exp_cnt = '{8'h58, 8'h58, 8'h59, 8'h59, 8'h59, 8'h59, 8'h00, 8'h00, 8'h01,
                    8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h04};
        quick_press(2'b10);
        tests_run++;
        if ({count_tens, count_ones} !== 8'h58) begin
            tests_failed++;
            $display("[TB] FAIL setup_58: cnt=%h%h, want 58", count_tens, count_ones);
        end
        signal = 2'b01;
        for (int k = 0; k < 17; k++) begin
            tick(1);
            got = {count_tens, count_ones, carry, active};
            exp = {exp_cnt[k], (k == 6), (k >= 2 && k <= 14)};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("[TB] FAIL repeat_wrap edge N+%0d: cnt=%h%h carry=%b active=%b, want %h",
                         k, count_tens, count_ones, carry, active, exp);
            end
            if (k == 12) signal = 2'b00;
        end
    endtask

    task automatic test_ignored();
        enable = 1'b1;
        signal = 2'b11;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            tests_run++;
            if ({count_tens, count_ones, active} !== {8'h04, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL conflict_idle cycle %0d: cnt=%h%h active=%b, want 04/0",
                         k, count_tens, count_ones, active);
            end
        end
        enable = 1'b0;
        signal = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            tests_run++;
            if ({count_tens, count_ones, active} !== {8'h04, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL disabled_idle cycle %0d: cnt=%h%h active=%b, want 04/0",
                         k, count_tens, count_ones, active);
            end
        end
        signal = 2'b00;
        tick(2);
    endtask

    task automatic test_enable_drop();
        logic [8:0] got;
        logic [8:0] exp;
        logic [7:0] exp_cnt [15];
        exp_cnt = '{8'h04, 8'h04, 8'h05, 8'h05, 8'h05, 8'h05, 8'h06, 8'h06,
                    8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07};
        enable = 1'b1;
        signal = 2'b01;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            got = {count_tens, count_ones, active};
            exp = {exp_cnt[k], (k >= 2 && k <= 8)};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("[TB] FAIL enable_drop edge N+%0d: cnt=%h%h active=%b, want %h",
                         k, count_tens, count_ones, active, exp);
            end
            if (k == 6) enable = 1'b0;
        end
        signal = 2'b00;
        enable = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid();
        logic [8:0] got;
        logic [8:0] exp;
        quick_press(2'b10);
        quick_press(2'b10);
        tests_run++;
        if ({count_tens, count_ones} !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL setup_05: cnt=%h%h, want 05", count_tens, count_ones);
        end
        signal = 2'b01;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            exp = {((k < 2) ? 8'h05 : (k < 6) ? 8'h06 : 8'h07), (k >= 2)};
            got = {count_tens, count_ones, active};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("[TB] FAIL pre_reset edge N+%0d: cnt=%h%h active=%b, want %h",
                         k, count_tens, count_ones, active, exp);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({count_tens, count_ones, carry, borrow, active} !== 11'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_clear: cnt=%h%h c=%b b=%b active=%b, want all 0",
                     count_tens, count_ones, carry, borrow, active);
        end
        tick(1);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            exp = {((k < 2) ? 8'h00 : 8'h01), (k >= 2)};
            got = {count_tens, count_ones, active};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("[TB] FAIL post_reset edge R+%0d: cnt=%h%h active=%b, want %h",
                         k, count_tens, count_ones, active, exp);
            end
        end
        signal = 2'b00;
        tick(5);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time %0t, want finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        enable       = 1'b0;
        signal       = 2'b00;
        test_reset();
        test_single_press();
        test_decrement_wrap();
        test_repeat_wrap();
        test_ignored();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/updown_step_counter.md
# updown_step_counter

Consumer end of the add/sub signalling path. It takes the 2-bit increment/decrement command and the register enable from the button-signal logic and applies them to a two-digit BCD register. A held button auto-repeats. Wrap-around is reported with one-cycle carry/borrow pulses. It is the settable register stage of the stopwatch, feeding the display decoders and the cascaded digit pair above it.

## Interface
- MAX_COUNT, 59, wrap value as a decimal integer; legal range 1..99.
- HOLD_CYCLES, 50_000_000, cycles a command must persist after its first step before auto-repeat starts; must be ≥ 2.
- REPEAT_CYCLES, 12_500_000, cycles between auto-repeat steps; must be ≥ 1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  register enable from the signal logic; when 0, the command is ignored.
- signal  in  2  command: 01 increment, 10 decrement, 00 idle, 11 conflict (treated as idle); asynchronous to clk.
- count_tens  out  4  BCD tens digit.
- count_ones  out  4  BCD ones digit.
- carry  out  1  one-cycle pulse when an increment wraps MAX_COUNT → 00.
- borrow  out  1  one-cycle pulse when a decrement wraps 00 → MAX_COUNT.
- active  out  1  high while the FSM is in PRESS or REPEAT.

## Operation
- signal and enable pass through a 2-flop synchronizer with reset value 0. The decoded command cmd is IDLE unless enable_s=1 and signal_s ∈ {01,10}.
- FSM states are IDLE, PRESS and REPEAT. A timer counts cycles within a state.
- IDLE: when cmd is valid, issue one step, latch the direction, go to PRESS and clear the timer.
- PRESS: on cmd IDLE, go to IDLE with no step. On the opposite direction, step once in the new direction, stay in PRESS and clear the timer. When the timer reaches HOLD_CYCLES-1, step, go to REPEAT and clear the timer. Otherwise increment the timer.
- REPEAT: on cmd IDLE, go to IDLE. On the opposite direction, step and go to PRESS. When the timer reaches REPEAT_CYCLES-1, step and clear the timer.
- Increment step: ones 9 → 0 with tens+1. At MAX_COUNT the count goes to 00 and carry=1.
- Decrement step: ones 0 → 9 with tens-1. At 00 the count goes to MAX_COUNT and borrow=1.
- At most one step occurs per cycle. carry and borrow are never both high.
- The count is only ever a legal BCD value ≤ MAX_COUNT.

## Timing
- Reset values: count_tens=0, count_ones=0, carry=0, borrow=0, active=0, state=IDLE, timer=0, synchronizer=0.
- Latency: if signal is sampled at edge N, the count is updated at edge N+2. carry and borrow are high for the cycle after that same edge.
- Step spacing while held:
  - first step at edge N+2;
  - second step HOLD_CYCLES edges later;
  - further steps every REPEAT_CYCLES edges.
- A command shorter than 1 cycle can be missed. This is accepted.
- Reset mid-operation clears everything at once. Because the synchronizer resets to 00, a command still held when rst_n rises counts as a new press. Its first step lands 2 edges after the first rising clk edge that sees rst_n=1.
- Timer width is $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)). The timer never overflows.

## Structure
- Shared package stopwatch_pkg holds:
  - cmd_t enum: CMD_IDLE, CMD_INC, CMD_DEC;
  - step_state_t enum: IDLE, PRESS, REPEAT;
  - the BCD digit typedef logic [3:0].
- Sub-module bcd_step is purely combinational. Inputs: tens, ones, dir, max_tens, max_ones. Outputs: next tens, next ones, wrap.
- The top level holds the synchronizer, FSM, timer and output registers.

## Test plan
Bench parameters: MAX_COUNT=59, HOLD_CYCLES=4, REPEAT_CYCLES=2.
- Reset release with signal=00 → count 00, carry=0, borrow=0, active=0 for 10 cycles.
- signal=01 and enable=1 held 3 cycles, then 00 → count 01 at edge N+2, exactly one step, active falls 2 cycles after release.
- From 00, signal=10 for 1 cycle → count 59 and borrow high for exactly one cycle.
- From 58, signal=01 held 12 cycles → steps to 59, 00 (carry pulse), 01, 02, 03, 04. Step times relative to the first step: +0, +4, +6, +8, +10, +12.
- signal=11 with enable=1 for 10 cycles → no change. Then signal=01 with enable=0 → no change. In REPEAT, dropping enable → stepping stops 2 cycles later.
- rst_n pulsed low during REPEAT at count 07 → count 00 immediately. With 01 still held, count is 01 two edges after the first active edge following release.
